cnt_scan_disp: RTL and testbench
================================

# cnt_scan_disp

Display back-end for the two-digit counter (QH/QL nibbles plus carry C). It registers the counter outputs and time-multiplexes them onto one 7-segment digit bus, with leading-zero blanking on the high digit. It also counts carry events modulo 10 and stretches each carry into a visible LED pulse. It sits directly downstream of the counter, between the counter and the board display.

## Interface
- SCAN_DIV, 4: clock cycles each digit stays selected (≥2).
- LED_HOLD, 8: clock cycles CLED stays high after a carry event (≥1).
- Clk  in  1  system clock, all logic on rising edge.
- MR  in  1  reset, synchronous, active-low.
- QH  in  4  counter high nibble.
- QL  in  4  counter low nibble.
- C  in  1  counter carry; any width ≥1 cycle.
- SEG  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- AN  out  2  digit select, one-hot active-high: 01 = low digit, 10 = high digit, 00 = blank.
- CLED  out  1  stretched carry indicator.
- CCNT  out  4  BCD count of carry events, 0..9.

## Operation
- Input stage:
  - QH, QL and C are registered every cycle into qh_r, ql_r and c_r.
  - c_rr holds the previous c_r.
  - carry event = c_r & ~c_rr. A wide C counts once.
- Scan FSM has three states:
  - IDLE: AN=00, SEG=0. Entered on reset. Left on the first edge with MR=1, going to SHOW_L.
  - SHOW_L: AN=01, SEG=enc(ql_r).
  - SHOW_H: AN=10, SEG=enc(qh_r). If qh_r==0, SEG=0 (leading-zero blank); AN stays 10.
- Scan timing:
  - Prescaler pcnt (width ceil(log2 SCAN_DIV)) is cleared on every state entry.
  - pcnt increments each cycle in SHOW_L/SHOW_H.
  - When pcnt==SCAN_DIV-1 the FSM toggles SHOW_L↔SHOW_H.
  - Each digit is shown exactly SCAN_DIV cycles. Full period is 2·SCAN_DIV.
- enc() mapping, {g..a}:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - A–F→40 (dash, g only).
- SEG and AN are registered and update on the same edge. They never show a mismatched digit/segment pair.
- Carry counter:
  - On a carry event, CCNT increments; 9 wraps to 0.
- LED stretcher:
  - hold counter hcnt is loaded with LED_HOLD on a carry event. Reload is allowed while already nonzero (retrigger).
  - Otherwise hcnt decrements when nonzero.
  - CLED = (hcnt != 0), registered.
- Reset: MR=0 at a rising edge forces, on that same edge:
  - SEG=0, AN=00, CLED=0, CCNT=0.
  - FSM=IDLE, pcnt=0, hcnt=0.
  - qh_r=ql_r=0, c_r=c_rr=0.
  - Reset mid-scan or mid-stretch aborts immediately; no partial pulse resumes.

## Timing
- Edge 0 is the first edge with MR=1: FSM goes IDLE→SHOW_L, and AN=01 appears after edge 0.
- SEG at edge 0 encodes ql_r, which is the QL sampled at the reset-release edge. During reset ql_r=0, so SEG=3F.
- Data latency: a QL/QH change before edge k reaches SEG after edge k+1, if that digit is selected.
- Carry latency:
  - C rises before edge k; c_r=1 after edge k; event is computed combinationally.
  - After edge k+1: CCNT updated and hcnt=LED_HOLD.
  - CLED high after edge k+2, and high for exactly LED_HOLD cycles absent retrigger.
- Simultaneous carry event and hcnt==1: load wins, so CLED stays high with no gap.
- Simultaneous carry event and CCNT==9: CCNT→0 and CLED retriggers.
- MR has priority over every other event on the same edge.

## Test plan
- Reset/hold: MR=0 for 50 cycles, QH=5, QL=7 → SEG=00, AN=00, CLED=0, CCNT=0 throughout. Release → AN=01 on the next edge, then alternates 01/10 every 4 cycles.
- Display: QH=1, QL=2 static, SCAN_DIV=4 → SEG=5B while AN=01, SEG=06 while AN=10; period 8 cycles.
- Blanking/invalid:
  - QH=0, QL=0 → AN=10 phases show SEG=00; AN=01 phases show 3F.
  - QL=A → SEG=40.
- Carry pulse:
  - 1-cycle C → CCNT 0→1, CLED high exactly 8 cycles starting 2 edges after C sampled.
  - A 5-cycle-wide C counts only once.
- Wrap/retrigger:
  - 10 carries spaced 20 cycles → CCNT 0..9 then 0.
  - Two carries 3 cycles apart → CLED continuous, low 8 cycles after the second.
- Integrated: drive from the real counter with MR pulsed low 20 cycles mid-run → all outputs zero during reset; scan restarts at AN=01; CCNT restarts from 0.

Source files
------------

// File: rtl/cnt_scan_disp.sv
// Two-digit 7-segment scan driver with leading-zero blanking, plus a mod-10 carry counter and a carry LED stretcher.
// Latency: input change reaches SEG two edges later, carry reaches CCNT two edges later and CLED three; no backpressure.
module cnt_scan_disp #(
  parameter int SCAN_DIV = 4,
  parameter int LED_HOLD = 8
) (
  input  logic       Clk,
  input  logic       MR,
  input  logic [3:0] QH,
  input  logic [3:0] QL,
  input  logic       C,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       CLED,
  output logic [3:0] CCNT
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(LED_HOLD + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LED_HOLD);

  typedef enum logic [1:0] {IDLE, SHOW_L, SHOW_H} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [3:0]    qh_q, ql_q;
  logic          c_q, c_prev_q;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic [3:0]    ccnt_q, ccnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          cled_q, cled_d;
  logic          carry_evt;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        state_d = SHOW_L;
        pcnt_d  = '0;
      end
      SHOW_L: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = SHOW_H;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      SHOW_H: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = SHOW_L;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pcnt_d  = '0;
      end
    endcase
  end

  // Decode from the next state so AN and SEG always switch together.
  always_comb begin
    an_d  = 2'b00;
    seg_d = 7'h00;
    case (state_d)
      SHOW_L: begin
        an_d  = 2'b01;
        seg_d = enc(ql_q);
      end
      SHOW_H: begin
        an_d  = 2'b10;
        seg_d = (qh_q == 4'd0) ? 7'h00 : enc(qh_q);
      end
      default: begin
        an_d  = 2'b00;
        seg_d = 7'h00;
      end
    endcase
  end

  always_comb begin
    carry_evt = c_q & ~c_prev_q;
    ccnt_d    = ccnt_q;
    hcnt_d    = hcnt_q;
    cled_d    = (hcnt_q != '0);
    if (carry_evt) begin
      ccnt_d = (ccnt_q == 4'd9) ? 4'd0 : ccnt_q + 4'd1;
      hcnt_d = HOLD_LOAD;
    end else if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!MR) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      qh_q     <= '0;
      ql_q     <= '0;
      c_q      <= 1'b0;
      c_prev_q <= 1'b0;
      seg_q    <= '0;
      an_q     <= '0;
      ccnt_q   <= '0;
      hcnt_q   <= '0;
      cled_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      qh_q     <= QH;
      ql_q     <= QL;
      c_q      <= C;
      c_prev_q <= c_q;
      seg_q    <= seg_d;
      an_q     <= an_d;
      ccnt_q   <= ccnt_d;
      hcnt_q   <= hcnt_d;
      cled_q   <= cled_d;
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign CLED = cled_q;
  assign CCNT = ccnt_q;

endmodule

// File: tb/tb_cnt_scan_disp.sv
module tb_cnt_scan_disp;
  localparam int SCAN_DIV = 4;
  localparam int LED_HOLD = 8;
  localparam int NEVER    = 1000;

  logic       Clk = 1'b0;
  logic       MR  = 1'b0;
  logic [3:0] QH  = 4'd0;
  logic [3:0] QL  = 4'd0;
  logic       C   = 1'b0;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       CLED;
  logic [3:0] CCNT;

  cnt_scan_disp #(.SCAN_DIV(SCAN_DIV), .LED_HOLD(LED_HOLD)) dut (
    .Clk(Clk), .MR(MR), .QH(QH), .QL(QL), .C(C),
    .SEG(SEG), .AN(AN), .CLED(CLED), .CCNT(CCNT)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       cled;
    logic [3:0] ccnt;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: input pipeline, cycles since release, edges since last carry event.
  logic [3:0] m_qh = 4'd0, m_ql = 4'd0;
  logic       m_c = 1'b0, m_cc = 1'b0;
  int         m_rel = -1;
  int         m_since = NEVER;
  int         m_ccnt = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tbl [0:9];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    seg_of = (v > 4'd9) ? 7'h40 : tbl[v];
  endfunction

  // Predict the outputs after the coming edge from the inputs about to be sampled, then advance one cycle.
  task automatic tick();
    obs_t e;
    logic evt;
    e = '0;
    if (!MR) begin
      m_qh = 4'd0; m_ql = 4'd0; m_c = 1'b0; m_cc = 1'b0;
      m_rel = -1; m_since = NEVER; m_ccnt = 0;
    end else begin
      m_rel = m_rel + 1;
      e.an = (((m_rel / SCAN_DIV) % 2) == 0) ? 2'b01 : 2'b10;
      if (e.an == 2'b01) e.seg = seg_of(m_ql);
      else               e.seg = (m_qh == 4'd0) ? 7'h00 : seg_of(m_qh);
      evt = m_c & ~m_cc;
      e.cled = (m_since + 1 <= LED_HOLD);
      if (evt) begin
        m_since = 0;
        m_ccnt = (m_ccnt + 1) % 10;
      end else if (m_since < NEVER) begin
        m_since = m_since + 1;
      end
      e.ccnt = 4'(m_ccnt);
      m_cc = m_c; m_c = C; m_qh = QH; m_ql = QL;
    end
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    MR = 1'b0; QH = 4'd5; QL = 4'd7; C = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) MR = 1'b1;
      tick();
      got = {SEG, AN, CLED, CCNT};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset[%0d]: got seg=%h an=%b cled=%b ccnt=%0d, want seg=%h an=%b cled=%b ccnt=%0d",
                 i, got.seg, got.an, got.cled, got.ccnt, want.seg, want.an, want.cled, want.ccnt);
      end
    end
  endtask

  task automatic test_display();
    obs_t got, want;
    QH = 4'd1; QL = 4'd2;
    for (int i = 0; i < 20; i++) begin
      tick();
      got = {SEG, AN, CLED, CCNT};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL display[%0d]: got seg=%h an=%b cled=%b ccnt=%0d, want seg=%h an=%b cled=%b ccnt=%0d",
                 i, got.seg, got.an, got.cled, got.ccnt, want.seg, want.an, want.cled, want.ccnt);
      end
    end
  endtask

  task automatic test_blank_invalid();
    obs_t got, want;
    logic [3:0] hs [0:3];
    logic [3:0] ls [0:3];
    hs = '{4'd0, 4'd3, 4'hF, 4'd9};
    ls = '{4'd0, 4'hA, 4'd8, 4'hE};
    for (int p = 0; p < 4; p++) begin
      QH = hs[p]; QL = ls[p];
      for (int i = 0; i < 16; i++) begin
        tick();
        got = {SEG, AN, CLED, CCNT};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL blank[%0d.%0d]: got seg=%h an=%b cled=%b ccnt=%0d, want seg=%h an=%b cled=%b ccnt=%0d",
                   p, i, got.seg, got.an, got.cled, got.ccnt, want.seg, want.an, want.cled, want.ccnt);
        end
      end
    end
  endtask

  task automatic test_carry_pulse();
    obs_t got, want;
    int highs;
    int widths [0:1];
    widths = '{1, 5};
    QH = 4'd4; QL = 4'd6;
    for (int p = 0; p < 2; p++) begin
      highs = 0;
      for (int i = 0; i < widths[p] + 16; i++) begin
        C = (i < widths[p]);
        tick();
        if (CLED) highs++;
        got = {SEG, AN, CLED, CCNT};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL carry[%0d.%0d]: got seg=%h an=%b cled=%b ccnt=%0d, want seg=%h an=%b cled=%b ccnt=%0d",
                   p, i, got.seg, got.an, got.cled, got.ccnt, want.seg, want.an, want.cled, want.ccnt);
        end
      end
      vectors++;
      if (highs != LED_HOLD) begin
        miscompares++;
        $display("FAIL carry_width[%0d]: CLED high %0d cycles, want %0d", p, highs, LED_HOLD);
      end
      vectors++;
      if (CCNT !== 4'(p + 1)) begin
        miscompares++;
        $display("FAIL carry_count[%0d]: CCNT=%0d, want %0d", p, CCNT, p + 1);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t got, want;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 20; i++) begin
        C = (i == 0);
        tick();
        got = {SEG, AN, CLED, CCNT};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL wrap[%0d.%0d]: got seg=%h an=%b cled=%b ccnt=%0d, want seg=%h an=%b cled=%b ccnt=%0d",
                   n, i, got.seg, got.an, got.cled, got.ccnt, want.seg, want.an, want.cled, want.ccnt);
        end
      end
    end
    vectors++;
    if (CCNT !== 4'd2) begin
      miscompares++;
      $display("FAIL wrap_final: CCNT=%0d, want 2", CCNT);
    end
  endtask

  // Second carry 3 edges after the first, then one landing exactly on hcnt==1.
  task automatic test_retrigger();
    obs_t got, want;
    int highs, rises;
    logic prev;
    int gaps [0:1];
    int want_high [0:1];
    gaps = '{3, LED_HOLD};
    want_high = '{3 + LED_HOLD, 2 * LED_HOLD};
    for (int p = 0; p < 2; p++) begin
      highs = 0; rises = 0; prev = CLED;
      for (int i = 0; i < gaps[p] + 20; i++) begin
        C = (i == 0) || (i == gaps[p]);
        tick();
        if (CLED) highs++;
        if (CLED && !prev) rises++;
        prev = CLED;
        got = {SEG, AN, CLED, CCNT};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL retrig[%0d.%0d]: got seg=%h an=%b cled=%b ccnt=%0d, want seg=%h an=%b cled=%b ccnt=%0d",
                   p, i, got.seg, got.an, got.cled, got.ccnt, want.seg, want.an, want.cled, want.ccnt);
        end
      end
      vectors++;
      if (highs != want_high[p] || rises != 1) begin
        miscompares++;
        $display("FAIL retrig_pulse[%0d]: high %0d cycles in %0d pulses, want %0d in 1",
                 p, highs, rises, want_high[p]);
      end
    end
  endtask

  task automatic test_integrated();
    obs_t got, want;
    int cnt;
    cnt = 90;
    for (int i = 0; i < 250; i++) begin
      QL = 4'(cnt % 10);
      QH = 4'(cnt / 10);
      C  = (cnt == 99);
      MR = !(i >= 100 && i < 120);
      tick();
      got = {SEG, AN, CLED, CCNT};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL integ[%0d]: got seg=%h an=%b cled=%b ccnt=%0d, want seg=%h an=%b cled=%b ccnt=%0d",
                 i, got.seg, got.an, got.cled, got.ccnt, want.seg, want.an, want.cled, want.ccnt);
      end
      cnt = (cnt + 1) % 100;
    end
    vectors++;
    if (CCNT !== 4'd1) begin
      miscompares++;
      $display("FAIL integ_final: CCNT=%0d, want 1", CCNT);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_blank_invalid();
    test_carry_pulse();
    test_wrap();
    test_retrigger();
    test_integrated();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
